calc_axis_times: RTL and testbench
==================================

Name: calc_axis_times

Overview:
- Computes per-axis motion phase durations (accelerate, cruise, decelerate, total) for five axes (x, y, z, e0, e1) from their trapezoidal motion parameters.
- Sits in the motion pipeline between the speed-to-parameters stage and the max-timing search stage.
- Driven by a level start and reports a level finish, so stages chain directly.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz; durations are expressed in clock cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level request; its rising edge launches a computation.
- params_x / params_y / params_z / params_e0 / params_e1  in  5x32 each (unpacked [0:4])  per-axis parameters:
  - [0] step count N
  - [1] start (jerk) speed v0, steps/s
  - [2] cruise speed v, steps/s
  - [3] acceleration a, steps/s²
  - [4] ramp step count Na
- timing_x / timing_y / timing_z / timing_e0 / timing_e1  out  4x64 each (unpacked [0:3])  per-axis durations in clk cycles:
  - [0] t_acc
  - [1] t_const
  - [2] t_dec
  - [3] t_total
- finish  out  1  results valid.

Behaviour:
- Reset (async, active-high): all timing words 0, finish 0, FSM to IDLE, divider cleared. Reset mid-computation aborts with no partial result kept.
- Start handling:
  - Rising edge of start (registered previous value) while in IDLE or DONE: clear finish and latch all 25 parameter words.
  - Inputs may change after the latch without affecting results.
- FSM: IDLE -> LOAD(axis) -> DIV_ACC -> DIV_CONST -> STORE -> next axis or DONE. Axes are processed in order x, y, z, e0, e1.
- Per-axis arithmetic (all unsigned, 64-bit, floor division):
  - Zero case: N==0 or v==0 -> all four words 0, both divisions skipped.
  - Flat profile: a==0 or v<=v0 -> t_acc = t_dec = 0, t_const = N·CLK_FREQ / v.
  - Otherwise:
    - t_acc = (v−v0)·CLK_FREQ / a
    - t_dec = t_acc
    - Ncruise = N − 2·Na, saturated to 0 if 2·Na ≥ N
    - t_const = Ncruise·CLK_FREQ / v
  - t_total = t_acc + t_const + t_dec.
  - Products are 32×32 -> 64 bits. The divisor is zero-extended to 64 bits.
- Timing words:
  - Updated at the STORE state of their axis.
  - During computation, words of axes not yet stored hold their previous values.
- DONE:
  - finish = 1, held while start remains high.
  - Start low -> finish 0 and FSM to IDLE; timing words are held.
  - A new start rising edge recomputes.
- Latency: ≤ 700 cycles from start edge to finish, with a 64-cycle restoring division and at most 10 divisions.
- start held high continuously does not retrigger.

Decomposition:
- Shared package:
  - parameter index constants: P_NUM=0, P_V0=1, P_V=2, P_ACC=3, P_NACC=4.
  - timing index constants: T_ACC=0, T_CONST=1, T_DEC=2, T_TOTAL=3.
  - FSM state enum.
- One sub-module: udiv64 (sequential 64/64 restoring divider).
  - Interface: start/busy/done, quotient.
  - Divide by zero returns 0; this case is unreachable by construction.

Test Plan:
- Trapezoid: x = {N=1000, v0=100, v=1100, a=10000, Na=60}, CLK_FREQ=50e6, others zero, raise start -> timing_x = {5_000_000, 40_000_000, 5_000_000, 50_000_000}; other axes all 0; finish within 700 cycles.
- Constant speed: y = {N=500, v0=0, v=1000, a=0, Na=0} -> timing_y = {0, 25_000_000, 0, 25_000_000}.
- Short move saturation: x with N=100, Na=60, rest as first scenario -> timing_x = {5_000_000, 0, 5_000_000, 10_000_000}.
- Zero move: N=0 or v=0 on e1 -> timing_e1 all 0, no hang, finish asserted.
- Handshake:
  - keep start high after finish -> no recompute;
  - drop start -> finish 0 next cycle;
  - raise start with new params -> new values and finish again.
- Async reset mid-division, asserted between clock edges -> finish 0 and timing words 0 immediately; subsequent start completes correctly.

Source files
------------

// File: rtl/calc_axis_times_pkg.sv
// Shared definitions for the per-axis phase-duration calculator.
// Holds the parameter/timing word indices, the controller state encoding
// and the cruise-step helper used by the top level.
package calc_axis_times_pkg;

    localparam int NUM_AXES = 5;

    localparam int P_NUM  = 0;
    localparam int P_V0   = 1;
    localparam int P_V    = 2;
    localparam int P_ACC  = 3;
    localparam int P_NACC = 4;

    localparam int T_ACC   = 0;
    localparam int T_CONST = 1;
    localparam int T_DEC   = 2;
    localparam int T_TOTAL = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_DIV_ACC   = 3'd2,
        S_DIV_CONST = 3'd3,
        S_STORE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Steps left for the cruise phase once both ramps are taken out;
    // a move too short for two full ramps has no cruise at all.
    function automatic logic [31:0] cruise_steps(input logic [31:0] n, input logic [31:0] na);
        logic [32:0] two_na;
        two_na = {na, 1'b0};
        if (two_na >= {1'b0, n})
            return 32'd0;
        else
            return n - two_na[31:0];
    endfunction

endpackage

// File: rtl/calc_axis_times_if.sv
// Bus between the speed-to-parameters stage, this calculator and the
// max-timing search stage.
//   start     : level request, rising edge launches a computation
//   params_*  : per-axis {N, v0, v, a, Na}
//   timing_*  : per-axis {t_acc, t_const, t_dec, t_total} in clk cycles
//   finish    : results valid
// master = upstream driver, slave = the calculator.
interface calc_axis_times_if;
    logic        start;
    logic [31:0] params_x  [0:4];
    logic [31:0] params_y  [0:4];
    logic [31:0] params_z  [0:4];
    logic [31:0] params_e0 [0:4];
    logic [31:0] params_e1 [0:4];
    logic [63:0] timing_x  [0:3];
    logic [63:0] timing_y  [0:3];
    logic [63:0] timing_z  [0:3];
    logic [63:0] timing_e0 [0:3];
    logic [63:0] timing_e1 [0:3];
    logic        finish;

    modport master (
        output start, params_x, params_y, params_z, params_e0, params_e1,
        input  timing_x, timing_y, timing_z, timing_e0, timing_e1, finish
    );

    modport slave (
        input  start, params_x, params_y, params_z, params_e0, params_e1,
        output timing_x, timing_y, timing_z, timing_e0, timing_e1, finish
    );
endinterface

// File: rtl/calc_axis_times_udiv64.sv
// Sequential 64/64 unsigned restoring divider, one quotient bit per clock.
//   clk, reset : clock, async active-high reset
//   start      : one-cycle request, operands sampled on this cycle
//   dividend   : 64-bit numerator
//   divisor    : 64-bit denominator (zero gives quotient 0)
//   busy       : iteration in progress
//   done       : one-cycle pulse, quotient valid from then on
//   quotient   : floor(dividend / divisor)
module udiv64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] quotient
);
    logic [63:0] rem;
    logic [63:0] quo;
    logic [63:0] dsr;
    logic [6:0]  count;
    logic [64:0] rem_sh;
    logic [65:0] trial;

    // Shifted remainder needs 65 bits: with a divisor above 2^63 the
    // previous remainder can already have its top bit set.
    always_comb begin
        rem_sh = {rem, quo[63]};
        trial  = {1'b0, rem_sh} - {2'b00, dsr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem <= '0;
                dsr <= divisor;
                if (divisor == 64'd0) begin
                    quo  <= '0;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    quo   <= dividend;
                    count <= 7'd64;
                    busy  <= 1'b1;
                end
            end else if (busy) begin
                if (!trial[65]) begin
                    rem <= trial[63:0];
                    quo <= {quo[62:0], 1'b1};
                end else begin
                    rem <= rem_sh[63:0];
                    quo <= {quo[62:0], 1'b0};
                end
                count <= count - 7'd1;
                if (count == 7'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;
endmodule

// File: rtl/calc_axis_times.sv
// Per-axis trapezoidal phase durations (accelerate, cruise, decelerate,
// total) for axes x, y, z, e0, e1, computed one axis at a time through a
// shared 64-bit divider.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of calc_axis_times_if (start/params in,
//                timing/finish out)
// CLK_FREQ sets the cycles-per-second scale of all durations.
module calc_axis_times
    import calc_axis_times_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    calc_axis_times_if.slave   bus
);
    localparam logic [63:0] CLK_W = 64'(CLK_FREQ);

    state_t      state;
    logic [2:0]  axis;
    logic        start_q;
    logic        start_rise;
    logic        finish_r;
    logic [31:0] prm [0:NUM_AXES-1][0:4];
    logic [63:0] tim [0:NUM_AXES-1][0:3];
    logic [63:0] t_acc;
    logic [63:0] t_const;

    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic [63:0] div_quotient;

    logic [31:0] cur_n, cur_v0, cur_v, cur_a, cur_na;
    logic        is_zero;
    logic        is_flat;
    logic [63:0] acc_dividend;
    logic [63:0] const_dividend;

    assign start_rise = bus.start & ~start_q;

    always_comb begin
        cur_n          = prm[axis][P_NUM];
        cur_v0         = prm[axis][P_V0];
        cur_v          = prm[axis][P_V];
        cur_a          = prm[axis][P_ACC];
        cur_na         = prm[axis][P_NACC];
        is_zero        = (cur_n == 32'd0) || (cur_v == 32'd0);
        is_flat        = (cur_a == 32'd0) || (cur_v <= cur_v0);
        acc_dividend   = 64'(cur_v - cur_v0) * CLK_W;
        const_dividend = 64'(is_flat ? cur_n : cruise_steps(cur_n, cur_na)) * CLK_W;
    end

    udiv64 u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            axis         <= '0;
            start_q      <= 1'b0;
            finish_r     <= 1'b0;
            t_acc        <= '0;
            t_const      <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            for (int i = 0; i < NUM_AXES; i++) begin
                for (int k = 0; k < 5; k++) prm[i][k] <= '0;
                for (int k = 0; k < 4; k++) tim[i][k] <= '0;
            end
        end else begin
            start_q   <= bus.start;
            div_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_rise) begin
                        finish_r <= 1'b0;
                        axis     <= '0;
                        state    <= S_LOAD;
                        for (int k = 0; k < 5; k++) begin
                            prm[0][k] <= bus.params_x[k];
                            prm[1][k] <= bus.params_y[k];
                            prm[2][k] <= bus.params_z[k];
                            prm[3][k] <= bus.params_e0[k];
                            prm[4][k] <= bus.params_e1[k];
                        end
                    end else if (state == S_DONE && !bus.start) begin
                        finish_r <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (!div_busy) begin
                        if (is_zero) begin
                            t_acc   <= '0;
                            t_const <= '0;
                            state   <= S_STORE;
                        end else if (is_flat) begin
                            t_acc        <= '0;
                            div_dividend <= const_dividend;
                            div_divisor  <= {32'd0, cur_v};
                            div_start    <= 1'b1;
                            state        <= S_DIV_CONST;
                        end else begin
                            div_dividend <= acc_dividend;
                            div_divisor  <= {32'd0, cur_a};
                            div_start    <= 1'b1;
                            state        <= S_DIV_ACC;
                        end
                    end
                end
                S_DIV_ACC: begin
                    if (div_done) begin
                        t_acc        <= div_quotient;
                        div_dividend <= const_dividend;
                        div_divisor  <= {32'd0, cur_v};
                        div_start    <= 1'b1;
                        state        <= S_DIV_CONST;
                    end
                end
                S_DIV_CONST: begin
                    if (div_done) begin
                        t_const <= div_quotient;
                        state   <= S_STORE;
                    end
                end
                S_STORE: begin
                    tim[axis][T_ACC]   <= t_acc;
                    tim[axis][T_CONST] <= t_const;
                    tim[axis][T_DEC]   <= t_acc;
                    tim[axis][T_TOTAL] <= t_acc + t_const + t_acc;
                    if (axis == 3'(NUM_AXES - 1)) begin
                        finish_r <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        axis  <= axis + 3'd1;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.finish = finish_r;

    for (genvar k = 0; k < 4; k++) begin : g_timing
        assign bus.timing_x[k]  = tim[0][k];
        assign bus.timing_y[k]  = tim[1][k];
        assign bus.timing_z[k]  = tim[2][k];
        assign bus.timing_e0[k] = tim[3][k];
        assign bus.timing_e1[k] = tim[4][k];
    end
endmodule

// File: tb/tb_calc_axis_times.sv
module tb_calc_axis_times;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    calc_axis_times_if bus ();

    calc_axis_times #(.CLK_FREQ(50_000_000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          ax;
        logic [31:0] n, v0, v, a, na;
        logic [63:0] e_acc, e_const, e_total;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_axis(input int ax, input logic [31:0] n, input logic [31:0] v0,
                            input logic [31:0] v, input logic [31:0] a, input logic [31:0] na);
        logic [31:0] p [0:4];
        p[0] = n; p[1] = v0; p[2] = v; p[3] = a; p[4] = na;
        for (int k = 0; k < 5; k++) begin
            case (ax)
                0: bus.params_x[k]  = p[k];
                1: bus.params_y[k]  = p[k];
                2: bus.params_z[k]  = p[k];
                3: bus.params_e0[k] = p[k];
                default: bus.params_e1[k] = p[k];
            endcase
        end
    endtask

    task automatic clear_all();
        for (int ax = 0; ax < 5; ax++) set_axis(ax, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [63:0] tget(input int ax, input int k);
        case (ax)
            0: return bus.timing_x[k];
            1: return bus.timing_y[k];
            2: return bus.timing_z[k];
            3: return bus.timing_e0[k];
            default: return bus.timing_e1[k];
        endcase
    endfunction

    function automatic logic [63:0] or_all_except(input int skip);
        logic [63:0] r = '0;
        for (int ax = 0; ax < 5; ax++)
            if (ax != skip)
                for (int k = 0; k < 4; k++) r |= tget(ax, k);
        return r;
    endfunction

    task automatic check_axis(input string name, input int ax, input logic [63:0] acc,
                              input logic [63:0] cst, input logic [63:0] tot);
        check($sformatf("%s_acc", name),   tget(ax, 0), acc);
        check($sformatf("%s_const", name), tget(ax, 1), cst);
        check($sformatf("%s_dec", name),   tget(ax, 2), acc);
        check($sformatf("%s_total", name), tget(ax, 3), tot);
    endtask

    // Drop start, raise it again and wait (bounded) for finish.
    task automatic run_calc(input string name);
        int cycles;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        cycles = 0;
        while (bus.finish !== 1'b1 && cycles < 800) begin
            @(negedge clk);
            cycles++;
        end
        check($sformatf("%s_latency_le_700", name), {63'd0, (cycles <= 700)}, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{"trap_x",      0, 1000, 100, 1100, 10000, 60, 5_000_000, 40_000_000, 50_000_000};
        vecs[1]  = '{"const_y",     1, 500, 0, 1000, 0, 0, 0, 25_000_000, 25_000_000};
        vecs[2]  = '{"short_x",     0, 100, 100, 1100, 10000, 60, 5_000_000, 0, 10_000_000};
        vecs[3]  = '{"zero_n_e1",   4, 0, 100, 1100, 10000, 60, 0, 0, 0};
        vecs[4]  = '{"zero_v_e1",   4, 1000, 0, 0, 10000, 60, 0, 0, 0};
        vecs[5]  = '{"flat_lt_z",   2, 300, 2000, 1000, 500, 10, 0, 15_000_000, 15_000_000};
        vecs[6]  = '{"flat_eq_z",   2, 300, 1000, 1000, 500, 10, 0, 15_000_000, 15_000_000};
        vecs[7]  = '{"floor_e0",    3, 1000, 0, 3000, 7000, 100, 21_428_571, 13_333_333, 56_190_475};
        vecs[8]  = '{"sat_eq_z",    2, 120, 100, 1100, 10000, 60, 5_000_000, 0, 10_000_000};
        vecs[9]  = '{"sat_m1_x",    0, 121, 100, 1100, 10000, 60, 5_000_000, 45_454, 10_045_454};
        vecs[10] = '{"wide_y",      1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 0, 0, 50_000_000, 50_000_000};

        reset     = 1'b1;
        bus.start = 1'b0;
        clear_all();
        repeat (3) @(negedge clk);
        check("reset_finish", {63'd0, bus.finish}, 64'd0);
        check("reset_timing", or_all_except(-1), 64'd0);
        reset = 1'b0;

        for (int i = 0; i <= 10; i++) begin
            clear_all();
            set_axis(vecs[i].ax, vecs[i].n, vecs[i].v0, vecs[i].v, vecs[i].a, vecs[i].na);
            run_calc(vecs[i].name);
            check_axis(vecs[i].name, vecs[i].ax, vecs[i].e_acc, vecs[i].e_const, vecs[i].e_total);
            check($sformatf("%s_others_zero", vecs[i].name), or_all_except(vecs[i].ax), 64'd0);
        end

        // All five axes loaded in one computation.
        set_axis(0, 1000, 100, 1100, 10000, 60);
        set_axis(1, 500, 0, 1000, 0, 0);
        set_axis(2, 300, 2000, 1000, 500, 10);
        set_axis(3, 1000, 0, 3000, 7000, 100);
        set_axis(4, 1000, 0, 0, 10000, 60);
        run_calc("all");
        check_axis("all_x",  0, 5_000_000, 40_000_000, 50_000_000);
        check_axis("all_y",  1, 0, 25_000_000, 25_000_000);
        check_axis("all_z",  2, 0, 15_000_000, 15_000_000);
        check_axis("all_e0", 3, 21_428_571, 13_333_333, 56_190_475);
        check_axis("all_e1", 4, 0, 0, 0);

        // start held high: new params must not retrigger.
        set_axis(0, 100, 100, 1100, 10000, 60);
        repeat (30) @(negedge clk);
        check("hold_finish", {63'd0, bus.finish}, 64'd1);
        check("hold_x_total", tget(0, 3), 64'd50_000_000);
        bus.start = 1'b0;
        @(negedge clk);
        check("drop_finish", {63'd0, bus.finish}, 64'd0);
        check("drop_x_total_held", tget(0, 3), 64'd50_000_000);
        run_calc("rerun");
        check_axis("rerun_x", 0, 5_000_000, 0, 10_000_000);

        // Params changed after the latch must not matter.
        clear_all();
        set_axis(0, 1000, 100, 1100, 10000, 60);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        repeat (5) @(negedge clk);
        set_axis(0, 7, 1, 2, 3, 1);
        begin
            int cycles = 0;
            while (bus.finish !== 1'b1 && cycles < 800) begin
                @(negedge clk);
                cycles++;
            end
            check("latch_latency_le_700", {63'd0, (cycles <= 695)}, 64'd1);
        end
        check_axis("latch_x", 0, 5_000_000, 40_000_000, 50_000_000);

        // Async reset mid-division, between clock edges.
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        repeat (100) @(negedge clk);
        #2;
        reset     = 1'b1;
        bus.start = 1'b0;
        #1;
        check("arst_finish", {63'd0, bus.finish}, 64'd0);
        check("arst_timing", or_all_except(-1), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        set_axis(0, 1000, 100, 1100, 10000, 60);
        run_calc("post_rst");
        check_axis("post_rst_x", 0, 5_000_000, 40_000_000, 50_000_000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
